hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: RAW scoreboard, dcache freeze, branch flush and perf counters
// Stall outputs are same-cycle combinational; redirect and counters are registered.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_wr,
  input  logic        b_taken,
  input  logic [31:0] b_pc,
  input  logic        dc_req,
  input  logic        dc_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] stall_cnt,
  output logic [15:0] br_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [31:0] pend;
  logic [2:0]  flush_cnt;

  logic        freeze;
  logic        in_run;
  logic        raw;
  logic        issue;
  logic        br_issue;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  // Hazard detection reads the registered scoreboard only, so a same-cycle
  // writeback does not release a dependent instruction until the next cycle.
  always_comb begin
    freeze      = dc_req & ~dc_ready;
    in_run      = (state == RUN);
    raw         = in_run & id_valid &
                  ((id_use_rs1 & pend[id_rs1]) | (id_use_rs2 & pend[id_rs2]));
    issue       = in_run & id_valid & ~freeze & ~raw;
    br_issue    = issue & b_taken;
    stall_id    = (state == BOOT) | freeze | raw;
    stall_if    = stall_id;
    flush_id_ex = raw & ~freeze;
    flush_if_id = (state == FLUSH) & ~freeze;

    set_vec = '0;
    if (issue && id_wr && (id_rd != 5'd0)) set_vec[id_rd] = 1'b1;
    clr_vec = '0;
    if (wb_valid && (state != BOOT)) clr_vec[wb_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= BOOT;
      pend           <= '0;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall_cnt      <= '0;
      br_cnt         <= '0;
    end else begin
      // Set is applied after clear so an issuing writer wins over a retiring one.
      pend           <= ((pend & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
      redirect_valid <= br_issue;
      if (br_issue) redirect_pc <= b_pc;

      if (stall_id && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (br_issue && (br_cnt != 16'hFFFF))         br_cnt    <= br_cnt + 16'd1;

      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (br_issue) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_INIT;
          end
        end
        FLUSH: begin
          if (!freeze) begin
            if (flush_cnt == 3'd0) state <= RUN;
            else                   flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven bench for hazard_ctrl plus reset and saturation sequences
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, id_wr;
  logic        b_taken;
  logic [31:0] b_pc;
  logic        dc_req, dc_ready, wb_valid;
  logic        stall_if, stall_id, flush_if_id, flush_id_ex, redirect_valid;
  logic [31:0] redirect_pc, stall_cnt;
  logic [15:0] br_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_wr(id_wr), .b_taken(b_taken), .b_pc(b_pc),
    .dc_req(dc_req), .dc_ready(dc_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall_if(stall_if), .stall_id(stall_id),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt), .br_cnt(br_cnt)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr;
    logic        bt;
    logic [31:0] bpc;
    logic        dq;
    logic        dr;
    logic        wv;
    logic [4:0]  wrd;
    logic        e_stall;
    logic        e_fifd;
    logic        e_fidex;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic [31:0] e_scnt;
    logic [15:0] e_bcnt;
  } vec_t;

  vec_t vecs [0:27];

  function automatic vec_t mk(
    logic iv, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
    logic [4:0] rd, logic wr, logic bt, logic [31:0] bpc,
    logic dq, logic dr, logic wv, logic [4:0] wrd,
    logic es, logic efi, logic efe, logic erv, logic [31:0] erpc,
    logic [31:0] escnt, logic [15:0] ebcnt);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.wr = wr; v.bt = bt; v.bpc = bpc;
    v.dq = dq; v.dr = dr; v.wv = wv; v.wrd = wrd;
    v.e_stall = es; v.e_fifd = efi; v.e_fidex = efe; v.e_rv = erv;
    v.e_rpc = erpc; v.e_scnt = escnt; v.e_bcnt = ebcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.iv; id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2; id_use_rs2 = v.u2;
    id_rd = v.rd; id_wr = v.wr; b_taken = v.bt; b_pc = v.bpc;
    dc_req = v.dq; dc_ready = v.dr; wb_valid = v.wv; wb_rd = v.wrd;
  endtask

  task automatic drive_idle();
    drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
  endtask

  initial begin
    //              iv rs1 u1 rs2 u2 rd wr bt bpc     dq dr wv wrd  st fi fe rv rpc     scnt bcnt
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,  1, 0, 0, 0, 0,      0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0,      0, 0, 0, 0,  0, 0, 0, 0, 0,      1, 0);
    vecs[2]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,  1, 0, 1, 0, 0,      1, 0);
    vecs[3]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,      0, 0, 1, 5,  1, 0, 1, 0, 0,      2, 0);
    vecs[4]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0, 0, 0,      3, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0,      0, 0, 1, 7,  0, 0, 0, 0, 0,      3, 0);
    vecs[6]  = mk(1, 0, 0, 7, 1, 0, 0, 0, 0,      0, 0, 0, 0,  1, 0, 1, 0, 0,      3, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 7,  0, 0, 0, 0, 0,      4, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 0, 0,  0, 0, 0, 0, 0,      4, 0);
    vecs[9]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0, 0, 0,      4, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0,  0, 0, 0, 0, 0,      4, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 3, 1, 1, 32'h200, 0, 0, 0, 0,  0, 1, 0, 1, 32'h100, 4, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 0, 0,  0, 1, 0, 0, 32'h100, 4, 1);
    vecs[13] = mk(1, 3, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0, 0, 32'h100, 4, 1);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 0, 0,  0, 0, 0, 0, 32'h100, 4, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,  0, 1, 0, 1, 32'h200, 4, 2);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 0,  1, 0, 0, 0, 32'h200, 4, 2);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 0,  1, 0, 0, 0, 32'h200, 5, 2);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 0,  1, 0, 0, 0, 32'h200, 6, 2);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 1, 0, 0,  0, 1, 0, 0, 32'h200, 7, 2);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0, 0, 32'h200, 7, 2);
    vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h300, 1, 0, 0, 0,  1, 0, 0, 0, 32'h200, 7, 2);
    vecs[22] = mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0, 0,  0, 0, 0, 0, 32'h200, 8, 2);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,  0, 1, 0, 1, 32'h300, 8, 3);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,  0, 1, 0, 0, 32'h300, 8, 3);
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0, 0, 32'h300, 8, 3);
    vecs[26] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,      1, 0, 0, 0,  1, 0, 0, 0, 32'h300, 8, 3);
    vecs[27] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0, 0, 32'h300, 9, 3);

    rst = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d stall_if", i),       32'(stall_if),       32'(vecs[i].e_stall));
      chk($sformatf("v%0d stall_id", i),       32'(stall_id),       32'(vecs[i].e_stall));
      chk($sformatf("v%0d flush_if_id", i),    32'(flush_if_id),    32'(vecs[i].e_fifd));
      chk($sformatf("v%0d flush_id_ex", i),    32'(flush_id_ex),    32'(vecs[i].e_fidex));
      chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d redirect_pc", i),    redirect_pc,         vecs[i].e_rpc);
      chk($sformatf("v%0d stall_cnt", i),      stall_cnt,           vecs[i].e_scnt);
      chk($sformatf("v%0d br_cnt", i),         32'(br_cnt),         32'(vecs[i].e_bcnt));
      @(negedge clk);
    end

    // Reset asserted while a redirect is pending in FLUSH.
    drive(mk(1,0,0,0,0, 0,0,1,32'h400, 0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    drive_idle();
    #1;
    chk("rstflush pre redirect_valid", 32'(redirect_valid), 32'd1);
    chk("rstflush pre redirect_pc", redirect_pc, 32'h400);
    rst = 1'b0;
    #1;
    chk("rstflush async redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rstflush async redirect_pc", redirect_pc, 32'd0);
    chk("rstflush async flush_if_id", 32'(flush_if_id), 32'd0);
    chk("rstflush async stall_cnt", stall_cnt, 32'd0);
    chk("rstflush async br_cnt", 32'(br_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("boot stall_id", 32'(stall_id), 32'd1);
    chk("boot stall_if", 32'(stall_if), 32'd1);
    chk("boot redirect_valid", 32'(redirect_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("run stall_id", 32'(stall_id), 32'd0);
    chk("run flush_if_id", 32'(flush_if_id), 32'd0);
    chk("run redirect_valid", 32'(redirect_valid), 32'd0);
    chk("run stall_cnt", stall_cnt, 32'd1);

    // stall_cnt saturation under a held freeze.
    @(negedge clk);
    dc_req = 1'b1; dc_ready = 1'b0;
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt;
    chk("sat stall_cnt start", stall_cnt, 32'hFFFF_FFFD);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("sat stall_cnt k%0d", k), stall_cnt,
          (k == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    end

    // br_cnt saturation across two taken branches.
    @(negedge clk);
    drive(mk(1,0,0,0,0, 0,0,1,32'h500, 0,0,0,0, 0,0,0,0,0,0,0));
    force dut.br_cnt = 16'hFFFE;
    #1;
    release dut.br_cnt;
    @(negedge clk);
    drive_idle();
    #1;
    chk("sat br_cnt first", 32'(br_cnt), 32'h0000_FFFF);
    chk("sat br redirect_pc first", redirect_pc, 32'h500);
    @(negedge clk);
    @(negedge clk);
    drive(mk(1,0,0,0,0, 0,0,1,32'h600, 0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    drive_idle();
    #1;
    chk("sat br_cnt second", 32'(br_cnt), 32'h0000_FFFF);
    chk("sat br redirect_valid second", 32'(redirect_valid), 32'd1);
    chk("sat br redirect_pc second", redirect_pc, 32'h600);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
